// File: rtl/vx_cache_flush_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vx_cache_flush_pkg
//  Brief    : Shared state encoding and geometry helpers for the writeback
//             flush sequencer (vx_cache_flush_ctrl, vx_cache_flush_walker).
//  Revision : 1.0 - initial release
// ============================================================================
package vx_cache_flush_pkg;

    // Flush sequencer states (3-bit encoding, kept as plain constants so
    // legacy code comparing raw state values keeps working).
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_CLEAN   = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    typedef logic [2:0] flush_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bank field width; a single-bank cache carries no bank bits.
    function automatic int bank_width(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Sets per bank.
    function automatic int num_lines(input int cache_size, input int line_size,
                                     input int banks, input int ways);
        return cache_size / (line_size * banks * ways);
    endfunction

    // Width of the store line index.
    function automatic int line_w(input int cache_size, input int line_size,
                                  input int banks, input int ways);
        return idx_width(num_lines(cache_size, line_size, banks, ways));
    endfunction

    // Width of the memory line address {tag, line, bank}.
    function automatic int addr_w(input int tag_width, input int cache_size,
                                  input int line_size, input int banks, input int ways);
        return tag_width + line_w(cache_size, line_size, banks, ways) + bank_width(banks);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_cache_flush_walker.sv
`default_nettype none
// ============================================================================
//  Module   : vx_cache_flush_walker
//  Brief    : (line, way) walk counter for the flush sequencer. Way is the
//             fast index; o_last flags the final (LINES-1, NUM_WAYS-1) slot.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_cache_flush_walker
    import vx_cache_flush_pkg::*;
#(
    parameter int LINES    = 64,
    parameter int NUM_WAYS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_clear,
    input  logic                           i_advance,
    output logic [idx_width(LINES)-1:0]    o_line,
    output logic [idx_width(NUM_WAYS)-1:0] o_way,
    output logic                           o_last
);

    localparam int LINE_W = idx_width(LINES);
    localparam int WAY_W  = idx_width(NUM_WAYS);

    logic [LINE_W-1:0] r_line;
    logic [WAY_W-1:0]  r_way;
    logic              w_way_last;
    logic              w_line_last;

    assign w_way_last  = (r_way  == WAY_W'(NUM_WAYS - 1));
    assign w_line_last = (r_line == LINE_W'(LINES - 1));

    // Step way first, carry into line; clear returns the walk to slot (0, 0).
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_line <= '0;
            r_way  <= '0;
        end else if (i_advance) begin
            if (w_way_last) begin
                r_way  <= '0;
                r_line <= r_line + LINE_W'(1);
            end else begin
                r_way  <= r_way + WAY_W'(1);
            end
        end
    end

    assign o_line = r_line;
    assign o_way  = r_way;
    assign o_last = w_way_last && w_line_last;

endmodule
`default_nettype wire

// File: rtl/vx_cache_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vx_cache_flush_ctrl
//  Brief    : Per-bank writeback flush sequencer. Stalls the bank pipeline,
//             walks every (line, way), writes back each valid dirty way with
//             its dirty byte mask, cleans it, then pulses o_flush_done.
//             Optional macro CS_FLUSH_PERF_EN adds the perf counter ports
//             o_perf_flush_lines and o_perf_flush_cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_cache_flush_ctrl
    import vx_cache_flush_pkg::*;
#(
    parameter int CACHE_SIZE = 16384,
    parameter int LINE_SIZE  = 64,
    parameter int NUM_BANKS  = 1,
    parameter int NUM_WAYS   = 4,
    parameter int BANK_ID    = 0,
    parameter int TAG_WIDTH  = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_flush_valid,
    output logic                        o_flush_ready,
    output logic                        o_flush_done,
    output logic                        o_pipe_stall,
    input  logic                        i_pipe_idle,
    output logic [line_w(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS)-1:0] o_st_line_sel,
    output logic [NUM_WAYS-1:0]         o_st_way_sel,
    output logic                        o_st_read,
    output logic                        o_st_clean,
    input  logic [TAG_WIDTH-1:0]        i_st_tag,
    input  logic                        i_st_tag_valid,
    input  logic [LINE_SIZE*8-1:0]      i_st_data,
    input  logic [LINE_SIZE-1:0]        i_st_byteen,
    output logic                        o_mem_req_valid,
    input  logic                        i_mem_req_ready,
    output logic [addr_w(TAG_WIDTH, CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS)-1:0] o_mem_req_addr,
    output logic [LINE_SIZE*8-1:0]      o_mem_req_data,
    output logic [LINE_SIZE-1:0]        o_mem_req_byteen
`ifdef CS_FLUSH_PERF_EN
    ,
    output logic [31:0]                 o_perf_flush_lines,
    output logic [31:0]                 o_perf_flush_cycles
`endif
);

    localparam int LINES  = num_lines(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
    localparam int LINE_W = idx_width(LINES);
    localparam int WAY_W  = idx_width(NUM_WAYS);
    localparam int BANK_W = bank_width(NUM_BANKS);
    localparam int ADDR_W = TAG_WIDTH + LINE_W + BANK_W;

    flush_state_t           r_state;
    flush_state_t           w_state_nxt;
    logic [LINE_W-1:0]      w_line;
    logic [WAY_W-1:0]       w_way;
    logic                   w_last;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_dirty;
    logic [ADDR_W-1:0]      w_cap_addr;
    logic [ADDR_W-1:0]      r_addr;
    logic [LINE_SIZE*8-1:0] r_data;
    logic [LINE_SIZE-1:0]   r_byteen;

    assign w_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_accept = (r_state == S_IDLE) && i_flush_valid;
    // Invalid ways can carry stale byte masks; only valid ways are written back.
    assign w_dirty  = i_st_tag_valid && (|i_st_byteen);

    vx_cache_flush_walker #(
        .LINES    (LINES),
        .NUM_WAYS (NUM_WAYS)
    ) u_walker (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == S_DONE),
        .i_advance ((r_state == S_NEXT) && !w_last),
        .o_line    (w_line),
        .o_way     (w_way),
        .o_last    (w_last)
    );

    // The bank field only exists when there is more than one bank.
    generate
        if (BANK_W > 0) begin : g_bank_field
            assign w_cap_addr = {i_st_tag, w_line, BANK_W'(BANK_ID)};
        end else begin : g_no_bank_field
            assign w_cap_addr = {i_st_tag, w_line};
        end
    endgenerate

    // State register; reset aborts any walk in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode for the flush walk.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (i_pipe_idle) w_state_nxt = S_READ;
            S_READ:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = w_dirty ? S_SEND : S_NEXT;
            S_SEND:    if (i_mem_req_ready) w_state_nxt = S_CLEAN;
            S_CLEAN:   w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = w_last ? S_DONE : S_READ;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the store read-out so the request payload is independent of
    // whatever the store drives while the request waits for the arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_byteen <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_addr   <= w_cap_addr;
            r_data   <= i_st_data;
            r_byteen <= i_st_byteen;
        end
    end

    assign o_flush_ready    = (r_state == S_IDLE);
    assign o_flush_done     = (r_state == S_DONE);
    assign o_pipe_stall     = w_busy;
    assign o_st_read        = (r_state == S_READ);
    assign o_st_clean       = (r_state == S_CLEAN);
    assign o_st_line_sel    = w_busy ? w_line : '0;
    assign o_st_way_sel     = w_busy ? (NUM_WAYS'(1) << w_way) : '0;
    assign o_mem_req_valid  = (r_state == S_SEND);
    assign o_mem_req_addr   = r_addr;
    assign o_mem_req_data   = r_data;
    assign o_mem_req_byteen = r_byteen;

`ifdef CS_FLUSH_PERF_EN
    logic [31:0] r_perf_lines;
    logic [31:0] r_perf_cycles;

    // Perf counters: restart on accept, count written ways and stalled cycles,
    // and hold their values once the walk finishes.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_perf_lines  <= '0;
            r_perf_cycles <= '0;
        end else begin
            if ((r_state == S_SEND) && i_mem_req_ready) begin
                r_perf_lines <= r_perf_lines + 32'd1;
            end
            if (w_busy) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
        end
    end

    assign o_perf_flush_lines  = r_perf_lines;
    assign o_perf_flush_cycles = r_perf_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_cache_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_cache_flush_ctrl
//  Brief    : Self-checking bench for vx_cache_flush_ctrl with a behavioural
//             tag/data store and a write-back reference list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vx_cache_flush_ctrl;

    localparam int CACHE_SIZE = 1024;
    localparam int LINE_SIZE  = 64;
    localparam int NUM_BANKS  = 2;
    localparam int NUM_WAYS   = 2;
    localparam int BANK_ID    = 1;
    localparam int TAG_WIDTH  = 20;
    localparam int LINES      = 4;
    localparam int AW         = 23;
    localparam int DW         = LINE_SIZE * 8;

    typedef struct packed {
        logic [AW-1:0]        addr;
        logic [DW-1:0]        data;
        logic [LINE_SIZE-1:0] be;
    } req_t;

    logic                  clk, reset;
    logic                  i_flush_valid, o_flush_ready, o_flush_done, o_pipe_stall, i_pipe_idle;
    logic [1:0]            o_st_line_sel;
    logic [NUM_WAYS-1:0]   o_st_way_sel;
    logic                  o_st_read, o_st_clean;
    logic [TAG_WIDTH-1:0]  i_st_tag;
    logic                  i_st_tag_valid;
    logic [DW-1:0]         i_st_data;
    logic [LINE_SIZE-1:0]  i_st_byteen;
    logic                  o_mem_req_valid, i_mem_req_ready;
    logic [AW-1:0]         o_mem_req_addr;
    logic [DW-1:0]         o_mem_req_data;
    logic [LINE_SIZE-1:0]  o_mem_req_byteen;
`ifdef CS_FLUSH_PERF_EN
    logic [31:0]           o_perf_flush_lines, o_perf_flush_cycles;
`endif

    vx_cache_flush_ctrl #(
        .CACHE_SIZE (CACHE_SIZE), .LINE_SIZE (LINE_SIZE), .NUM_BANKS (NUM_BANKS),
        .NUM_WAYS (NUM_WAYS), .BANK_ID (BANK_ID), .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk (clk), .reset (reset),
        .i_flush_valid (i_flush_valid), .o_flush_ready (o_flush_ready),
        .o_flush_done (o_flush_done), .o_pipe_stall (o_pipe_stall), .i_pipe_idle (i_pipe_idle),
        .o_st_line_sel (o_st_line_sel), .o_st_way_sel (o_st_way_sel),
        .o_st_read (o_st_read), .o_st_clean (o_st_clean),
        .i_st_tag (i_st_tag), .i_st_tag_valid (i_st_tag_valid),
        .i_st_data (i_st_data), .i_st_byteen (i_st_byteen),
        .o_mem_req_valid (o_mem_req_valid), .i_mem_req_ready (i_mem_req_ready),
        .o_mem_req_addr (o_mem_req_addr), .o_mem_req_data (o_mem_req_data),
        .o_mem_req_byteen (o_mem_req_byteen)
`ifdef CS_FLUSH_PERF_EN
        , .o_perf_flush_lines (o_perf_flush_lines), .o_perf_flush_cycles (o_perf_flush_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural store contents
    logic                 s_valid  [LINES][NUM_WAYS];
    logic [TAG_WIDTH-1:0] s_tag    [LINES][NUM_WAYS];
    logic [LINE_SIZE-1:0] s_byteen [LINES][NUM_WAYS];
    logic [DW-1:0]        s_data   [LINES][NUM_WAYS];

    int   n_checks = 0, n_pass = 0;
    int   cyc = 0, done_cnt = 0, done_cyc = 0, first_read = -1;
    int   wait_cycles = 0, stab_err = 0, stall_cyc = 0, holdoff_err = 0;
    int   clean_line_last = -1;
    logic [NUM_WAYS-1:0] clean_sel_last;
    bit   rdy_rand = 1'b0;
    bit   prev_pending = 1'b0;
    req_t prev_req;
    req_t got_q[$], exp_q[$];
    int   got_clean[$], exp_clean[$];

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int way_of(input logic [NUM_WAYS-1:0] sel);
        return sel[1] ? 1 : 0;
    endfunction

    // Store: registered read on st_read, garbage otherwise; st_clean wipes dirty bytes.
    always @(posedge clk) begin
        if (o_st_read) begin
            i_st_tag       <= s_tag[o_st_line_sel][way_of(o_st_way_sel)];
            i_st_tag_valid <= s_valid[o_st_line_sel][way_of(o_st_way_sel)];
            i_st_byteen    <= s_byteen[o_st_line_sel][way_of(o_st_way_sel)];
            i_st_data      <= s_data[o_st_line_sel][way_of(o_st_way_sel)];
        end else begin
            i_st_tag       <= TAG_WIDTH'($urandom);
            i_st_tag_valid <= 1'($urandom);
            i_st_byteen    <= {$urandom, $urandom};
            i_st_data      <= rand_line();
        end
        if (o_st_clean) s_byteen[o_st_line_sel][way_of(o_st_way_sel)] = '0;
    end

    // Random arbiter backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rdy_rand) i_mem_req_ready = ($urandom_range(0, 2) != 0);
    end

    // Monitor sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_pending = 1'b0;
        end else begin
            if (o_mem_req_valid && i_mem_req_ready)
                got_q.push_back('{o_mem_req_addr, o_mem_req_data, o_mem_req_byteen});
            if (o_mem_req_valid && !i_mem_req_ready) wait_cycles++;
            if (prev_pending && (!o_mem_req_valid ||
                (req_t'{o_mem_req_addr, o_mem_req_data, o_mem_req_byteen} != prev_req)))
                stab_err++;
            prev_pending = o_mem_req_valid && !i_mem_req_ready;
            prev_req     = '{o_mem_req_addr, o_mem_req_data, o_mem_req_byteen};
            if (o_st_clean) begin
                got_clean.push_back(int'(o_st_line_sel) * NUM_WAYS + way_of(o_st_way_sel));
                clean_line_last = int'(o_st_line_sel);
                clean_sel_last  = o_st_way_sel;
            end
            if (o_st_read && first_read < 0) first_read = cyc;
            if (o_flush_done) begin done_cnt++; done_cyc = cyc; end
            if (o_pipe_stall) stall_cyc++;
            if (o_pipe_stall && o_flush_ready) holdoff_err++;
        end
    end

    task automatic store_fill(input int dirty_pct);
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < NUM_WAYS; w++) begin
                s_valid[l][w]  = (dirty_pct == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_tag[l][w]    = TAG_WIDTH'($urandom);
                s_data[l][w]   = rand_line();
                s_byteen[l][w] = ($urandom_range(0, 99) < dirty_pct) ? ({$urandom, $urandom} | 64'h1) : '0;
            end
    endtask

    // Reference: one write per valid dirty way in (line, way) order, addr = {tag, line, bank}
    task automatic build_expect(output int nd);
        exp_q.delete(); exp_clean.delete(); nd = 0;
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < NUM_WAYS; w++)
                if (s_valid[l][w] && s_byteen[l][w] != '0) begin
                    exp_q.push_back('{(AW'(s_tag[l][w]) << 3) | (AW'(l) << 1) | AW'(BANK_ID),
                                      s_data[l][w], s_byteen[l][w]});
                    exp_clean.push_back(l * NUM_WAYS + w);
                    nd++;
                end
    endtask

    task automatic start_flush(input bit hold);
        got_q.delete(); got_clean.delete();
        first_read = -1; wait_cycles = 0; stab_err = 0; stall_cyc = 0;
        @(posedge clk); #1;
        i_flush_valid = 1'b1;
        if (!hold) begin @(posedge clk); #1; i_flush_valid = 1'b0; end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt != start) begin ok = 1'b1; break; end
        end
        i_flush_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_flush_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", o_flush_ready); else n_pass++;
        n_checks++; if (o_flush_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", o_flush_done); else n_pass++;
        n_checks++; if (o_pipe_stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", o_pipe_stall); else n_pass++;
        n_checks++; if ({o_st_read, o_st_clean, o_mem_req_valid} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000", {o_st_read, o_st_clean, o_mem_req_valid}); else n_pass++;
        n_checks++; if ({o_mem_req_addr, o_mem_req_byteen, o_st_line_sel, o_st_way_sel} !== '0)
            $display("FAIL reset_payload: got addr %h be %h line %0d way %b want all 0",
                     o_mem_req_addr, o_mem_req_byteen, o_st_line_sel, o_st_way_sel); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_no_dirty();
        bit ok; int nd;
        store_fill(0);
        for (int w = 0; w < NUM_WAYS; w++) s_byteen[1][w] = 64'hFFFF;  // invalid ways with stale mask
        s_valid[1][0] = 1'b0; s_valid[1][1] = 1'b0;
        build_expect(nd);
        i_mem_req_ready = 1'b1;
        start_flush(1'b0);
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL nodirty_done: got timeout want done"); else n_pass++;
        n_checks++; if (got_q.size() !== nd) $display("FAIL nodirty_reqs: got %0d want %0d", got_q.size(), nd); else n_pass++;
        n_checks++; if (done_cyc - first_read !== 3 * LINES * NUM_WAYS)
            $display("FAIL nodirty_latency: got %0d want %0d", done_cyc - first_read, 3 * LINES * NUM_WAYS); else n_pass++;
        n_checks++; if (o_flush_done !== 1'b0) $display("FAIL nodirty_done_width: got %0b want 0", o_flush_done); else n_pass++;
    endtask

    task automatic test_single_dirty();
        bit ok;
        store_fill(0);
        s_tag[2][1] = 20'h5; s_byteen[2][1] = 64'hF0;
        i_mem_req_ready = 1'b1;
        start_flush(1'b0);
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL single_done: got timeout want done"); else n_pass++;
        n_checks++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0].addr !== 23'h2D) $display("FAIL single_addr: got %h want 2d", got_q[0].addr); else n_pass++;
            n_checks++; if (got_q[0].be !== 64'hF0) $display("FAIL single_byteen: got %h want f0", got_q[0].be); else n_pass++;
            n_checks++; if (got_q[0].data !== s_data[2][1]) $display("FAIL single_data: got %h want %h", got_q[0].data[63:0], s_data[2][1][63:0]); else n_pass++;
        end
        n_checks++; if (got_clean.size() !== 1 || clean_line_last !== 2 || clean_sel_last !== 2'b10)
            $display("FAIL single_clean: got n=%0d line %0d sel %b want n=1 line 2 sel 10",
                     got_clean.size(), clean_line_last, clean_sel_last); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok; int bad; req_t held; logic [1:0] line_held;
        store_fill(0);
        s_byteen[1][0] = 64'h0F0F_0000_0000_00FF;
        i_mem_req_ready = 1'b0;
        start_flush(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin @(posedge clk); #1; ok = o_mem_req_valid; end
        n_checks++; if (!ok) $display("FAIL bp_valid: got timeout want mem_req_valid"); else n_pass++;
        held = '{o_mem_req_addr, o_mem_req_data, o_mem_req_byteen};
        line_held = o_st_line_sel;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!o_mem_req_valid || o_st_read || o_st_clean || o_st_line_sel != line_held ||
                req_t'{o_mem_req_addr, o_mem_req_data, o_mem_req_byteen} != held) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (held.addr !== ((AW'(s_tag[1][0]) << 3) | (AW'(1) << 1) | AW'(BANK_ID)) || held.data !== s_data[1][0])
            $display("FAIL bp_payload: got addr %h want %h", held.addr, (AW'(s_tag[1][0]) << 3) | 23'h3); else n_pass++;
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_st_clean !== 1'b1) $display("FAIL bp_clean: got %0b want 1", o_st_clean); else n_pass++;
        wait_done(200, ok);
        n_checks++; if (!ok || got_q.size() !== 1) $display("FAIL bp_finish: got done %0b reqs %0d want 1/1", ok, got_q.size()); else n_pass++;
    endtask

    task automatic test_drain();
        bit ok; int bad;
        store_fill(0);
        i_pipe_idle = 1'b0;
        start_flush(1'b0);
        bad = 0;
        repeat (5) begin
            if (!o_pipe_stall || o_st_read) bad++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad !== 0) $display("FAIL drain_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (first_read !== -1) $display("FAIL drain_early_read: got read at %0d want none", first_read); else n_pass++;
        i_pipe_idle = 1'b1;
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL drain_done: got timeout want done"); else n_pass++;
    endtask

    task automatic test_reset_in_send();
        bit ok; int d0;
        store_fill(0);
        s_byteen[0][1] = 64'h3;
        i_mem_req_ready = 1'b0;
        start_flush(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin @(posedge clk); #1; ok = o_mem_req_valid; end
        n_checks++; if (!ok) $display("FAIL rst_send_reach: got timeout want SEND"); else n_pass++;
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_mem_req_valid !== 1'b0 || o_flush_ready !== 1'b1)
            $display("FAIL rst_send_state: got valid %0b ready %0b want 0/1", o_mem_req_valid, o_flush_ready); else n_pass++;
        reset = 1'b0;
        i_mem_req_ready = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_checks++; if (done_cnt !== d0 || o_pipe_stall !== 1'b0)
            $display("FAIL rst_send_nodone: got done %0d stall %0b want %0d/0", done_cnt, o_pipe_stall, d0); else n_pass++;
    endtask

    task automatic test_random();
        bit ok; int nd, mism, cmism;
        for (int it = 0; it < 6; it++) begin
            store_fill(50);
            build_expect(nd);
            rdy_rand = (it % 2) == 1;
            if (!rdy_rand) i_mem_req_ready = 1'b1;
            start_flush(1'b1);   // request held high across the walk
            wait_done(1000, ok);
            rdy_rand = 1'b0;
            i_mem_req_ready = 1'b1;
            n_checks++; if (!ok) $display("FAIL rand%0d_done: got timeout want done", it); else n_pass++;
            n_checks++; if (got_q.size() !== exp_q.size())
                $display("FAIL rand%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); else n_pass++;
            mism = 0; cmism = 0;
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) mism++;
            for (int k = 0; k < got_clean.size() && k < exp_clean.size(); k++) if (got_clean[k] !== exp_clean[k]) cmism++;
            n_checks++; if (mism !== 0) $display("FAIL rand%0d_payload: got %0d mismatching reqs want 0", it, mism); else n_pass++;
            n_checks++; if (cmism !== 0 || got_clean.size() !== exp_clean.size())
                $display("FAIL rand%0d_clean: got %0d cleans (%0d wrong) want %0d", it, got_clean.size(), cmism, exp_clean.size()); else n_pass++;
            n_checks++; if (done_cyc - first_read !== 3 * LINES * NUM_WAYS + 2 * nd + wait_cycles)
                $display("FAIL rand%0d_latency: got %0d want %0d", it, done_cyc - first_read,
                         3 * LINES * NUM_WAYS + 2 * nd + wait_cycles); else n_pass++;
            n_checks++; if (stab_err !== 0) $display("FAIL rand%0d_stable: got %0d changes want 0", it, stab_err); else n_pass++;
            repeat (3) @(posedge clk);
            #1;
            n_checks++; if (o_pipe_stall !== 1'b0) $display("FAIL rand%0d_requeue: got stall %0b want 0", it, o_pipe_stall); else n_pass++;
        end
        n_checks++; if (holdoff_err !== 0) $display("FAIL holdoff: got %0d ready-while-busy cycles want 0", holdoff_err); else n_pass++;
    endtask

`ifdef CS_FLUSH_PERF_EN
    task automatic test_perf();
        bit ok;
        store_fill(0);
        s_byteen[0][0] = 64'h1; s_byteen[1][1] = 64'h80; s_byteen[3][0] = 64'hFF00;
        i_mem_req_ready = 1'b1;
        start_flush(1'b0);
        wait_done(300, ok);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (!ok || o_perf_flush_lines !== 32'd3)
            $display("FAIL perf_lines: got %0d want 3", o_perf_flush_lines); else n_pass++;
        n_checks++; if (o_perf_flush_cycles !== 32'(stall_cyc))
            $display("FAIL perf_cycles: got %0d want %0d", o_perf_flush_cycles, stall_cyc); else n_pass++;
        store_fill(0);
        start_flush(1'b0);
        wait_done(300, ok);
        #1;
        n_checks++; if (!ok || o_perf_flush_lines !== 32'd0)
            $display("FAIL perf_lines_clear: got %0d want 0", o_perf_flush_lines); else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; i_flush_valid = 1'b0; i_pipe_idle = 1'b1; i_mem_req_ready = 1'b0;
        test_reset();
        test_no_dirty();
        test_single_dirty();
        test_backpressure();
        test_drain();
        test_reset_in_send();
        test_random();
`ifdef CS_FLUSH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
